// File: rtl/common_core_pkg.sv
// Shared definitions for the SGPIO sideband blocks: link state encoding and
// default frame/timeout sizing.
package common_core_pkg;

    localparam int unsigned SGPIO_NBITS_DEF   = 64;
    localparam int unsigned SGPIO_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } sgpio_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for one asynchronous input, with an optional third
// stage that produces single-clk rise/fall pulses on the synchronized level.
module sync_edge_det #(
    parameter bit RST_VAL  = 1'b0,
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

    generate
        if (EDGE_DET) begin : g_edge
            logic s3_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_q <= RST_VAL;
                end else begin
                    s3_q <= s2_q;
                end
            end

            assign rise = s2_q & ~s3_q;
            assign fall = ~s2_q & s3_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sgpio_bmc_target.sv
// SGPIO target on the BMC link: deserializes BMC frames into o_rx_data and
// serializes i_tx_data back, with framing checks and loss-of-clock detection.
module sgpio_bmc_target
    import common_core_pkg::*;
#(
    parameter int unsigned NBITS       = SGPIO_NBITS_DEF,
    parameter int unsigned TIMEOUT_CYC = SGPIO_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             i_resetn,
    input  logic             i_sgpio_clk,
    input  logic             i_sgpio_ld_n,
    input  logic             i_sgpio_dout,
    output logic             o_sgpio_din,
    input  logic [NBITS-1:0] i_tx_data,
    output logic [NBITS-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_frame_err,
    output logic             o_link_active
);

    localparam int unsigned CNT_W  = $clog2(NBITS + 2);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(NBITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);

    sgpio_state_t      state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [NBITS-1:0]  rx_shift_q;
    logic [NBITS-1:0]  tx_shift_q;
    logic [NBITS-1:0]  rx_next;

    logic sclk_q, sclk_rise, sclk_fall;
    logic ld_q, ld_rise, ld_fall;
    logic dout_q, dout_rise, dout_fall;
    logic sclk_edge;
    logic timeout;
    logic frame_ok;

    sync_edge_det #(.RST_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_sclk (
        .clk   (clk),
        .rst_n (i_resetn),
        .d     (i_sgpio_clk),
        .q     (sclk_q),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1), .EDGE_DET(1'b0)) u_sync_ld_n (
        .clk   (clk),
        .rst_n (i_resetn),
        .d     (i_sgpio_ld_n),
        .q     (ld_q),
        .rise  (ld_rise),
        .fall  (ld_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_dout (
        .clk   (clk),
        .rst_n (i_resetn),
        .d     (i_sgpio_dout),
        .q     (dout_q),
        .rise  (dout_rise),
        .fall  (dout_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_q, ld_rise, ld_fall, dout_rise, dout_fall};

    always_comb begin
        sclk_edge = sclk_rise | sclk_fall;
        // An SCLK edge in the same clk as the timeout wins: no timeout then.
        timeout   = ~sclk_edge && (idle_cnt_q == IDLE_LAST);
        frame_ok  = (bit_cnt_q == CNT_LAST);
        rx_next   = {dout_q, rx_shift_q[NBITS-1:1]};
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            idle_cnt_q <= '0;
        end else if (sclk_edge) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_sgpio_din <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            if (timeout) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
                tx_shift_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sclk_edge) begin
                            state_q <= ST_SYNC;
                        end
                    end
                    ST_SYNC, ST_ACTIVE: begin
                        if (sclk_rise) begin
                            rx_shift_q <= rx_next;
                            if (!ld_q) begin
                                // Frame end; the SYNC frame only aligns us.
                                bit_cnt_q  <= '0;
                                tx_shift_q <= i_tx_data;
                                state_q    <= ST_ACTIVE;
                                if (state_q == ST_ACTIVE) begin
                                    if (frame_ok) begin
                                        o_rx_data  <= rx_next;
                                        o_rx_valid <= 1'b1;
                                    end else begin
                                        o_frame_err <= 1'b1;
                                    end
                                end
                            end else if (bit_cnt_q != CNT_SAT) begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (sclk_fall) begin
                            o_sgpio_din <= tx_shift_q[0];
                            tx_shift_q  <= {1'b0, tx_shift_q[NBITS-1:1]};
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_link_active = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_sgpio_bmc_target.sv
// Directed bench for sgpio_bmc_target with NBITS=8, TIMEOUT_CYC=64 and an
// SGPIO clock of clk/8 driven like a BMC master.
module tb_sgpio_bmc_target;

    logic       clk;
    logic       i_resetn;
    logic       i_sgpio_clk;
    logic       i_sgpio_ld_n;
    logic       i_sgpio_dout;
    logic       o_sgpio_din;
    logic [7:0] i_tx_data;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_link_active;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;

    sgpio_bmc_target #(
        .NBITS       (8),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk           (clk),
        .i_resetn      (i_resetn),
        .i_sgpio_clk   (i_sgpio_clk),
        .i_sgpio_ld_n  (i_sgpio_ld_n),
        .i_sgpio_dout  (i_sgpio_dout),
        .o_sgpio_din   (o_sgpio_din),
        .i_tx_data     (i_tx_data),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .o_frame_err   (o_frame_err),
        .o_link_active (o_link_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        valid_cnt = 0;
        err_cnt   = 0;
    end

    always @(negedge clk) begin
        if (o_rx_valid === 1'b1) valid_cnt = valid_cnt + 1;
        if (o_frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SGPIO bit: falling edge with new data, 4 clk low, BMC samples
    // din, rising edge, 4 clk high.
    task automatic bit_cycle(input logic d, input logic ld, output logic din);
        @(negedge clk);
        i_sgpio_clk  = 1'b0;
        i_sgpio_dout = d;
        i_sgpio_ld_n = ld;
        repeat (4) @(negedge clk);
        din = o_sgpio_din;
        i_sgpio_clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input int chg_bit,
                              input logic [7:0] chg_val, output logic [7:0] din_bits);
        logic b;
        din_bits = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) i_tx_data = chg_val;
            bit_cycle(data[i], (i == nbits - 1) ? 1'b0 : 1'b1, b);
            din_bits[i] = b;
        end
        @(negedge clk);
    endtask

    logic [7:0] din;
    logic       b0;
    int         v0;
    int         e0;

    initial begin
        checks       = 0;
        errors       = 0;
        i_resetn     = 1'b0;
        i_sgpio_clk  = 1'b0;
        i_sgpio_ld_n = 1'b1;
        i_sgpio_dout = 1'b0;
        i_tx_data    = 8'h00;

        wait_neg(3);
        check("rst_rx_data", o_rx_data, 8'h00);
        check("rst_rx_valid", o_rx_valid, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_link", o_link_active, 1'b0);
        check("rst_din", o_sgpio_din, 1'b0);
        i_resetn = 1'b1;
        wait_neg(2);

        // Alignment frame, then first good frame.
        i_tx_data = 8'h3C;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hA5, 8, -1, 8'h00, din);
        check("f1_no_valid", valid_cnt - v0, 0);
        check("f1_no_err", err_cnt - e0, 0);
        check("f1_link", o_link_active, 1'b1);

        i_tx_data = 8'hFF;
        v0 = valid_cnt;
        send_frame(8'hA5, 8, -1, 8'h00, din);
        check("f2_valid", valid_cnt - v0, 1);
        check("f2_rx_data", o_rx_data, 8'hA5);
        check("f2_din_3c", din, 8'h3C);

        // tx changes mid-frame: current frame still returns the old value.
        v0 = valid_cnt;
        send_frame(8'h5A, 8, 3, 8'h00, din);
        check("f3_valid", valid_cnt - v0, 1);
        check("f3_rx_data", o_rx_data, 8'h5A);
        check("f3_din_ff", din, 8'hFF);

        v0 = valid_cnt;
        send_frame(8'h3C, 8, -1, 8'h00, din);
        check("f4_valid", valid_cnt - v0, 1);
        check("f4_rx_data", o_rx_data, 8'h3C);
        check("f4_din_00", din, 8'h00);

        // Short frame.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h0F, 6, -1, 8'h00, din);
        check("short_err", err_cnt - e0, 1);
        check("short_no_valid", valid_cnt - v0, 0);
        check("short_rx_kept", o_rx_data, 8'h3C);

        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hC3, 8, -1, 8'h00, din);
        check("after_short_valid", valid_cnt - v0, 1);
        check("after_short_no_err", err_cnt - e0, 0);
        check("after_short_rx", o_rx_data, 8'hC3);

        // Stop SCLK.
        wait_neg(60);
        check("to_still_active", o_link_active, 1'b1);
        wait_neg(5);
        check("to_link_lost", o_link_active, 1'b0);
        check("to_rx_kept", o_rx_data, 8'hC3);

        i_tx_data = 8'hFF;
        v0 = valid_cnt;
        send_frame(8'h11, 8, -1, 8'h00, din);
        check("resume_no_valid", valid_cnt - v0, 0);
        check("resume_link", o_link_active, 1'b1);
        v0 = valid_cnt;
        send_frame(8'h22, 8, -1, 8'h00, din);
        check("resume_valid", valid_cnt - v0, 1);
        check("resume_rx", o_rx_data, 8'h22);
        check("resume_din_ff", din, 8'hFF);

        // Reset at bit 4 of a frame.
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b1, b0);
        @(negedge clk);
        i_sgpio_clk  = 1'b0;
        i_sgpio_dout = 1'b0;
        i_sgpio_ld_n = 1'b1;
        wait_neg(2);
        check("pre_rst_din", o_sgpio_din, 1'b1);
        i_resetn = 1'b0;
        #1;
        check("mid_rst_rx_data", o_rx_data, 8'h00);
        check("mid_rst_valid", o_rx_valid, 1'b0);
        check("mid_rst_err", o_frame_err, 1'b0);
        check("mid_rst_link", o_link_active, 1'b0);
        check("mid_rst_din", o_sgpio_din, 1'b0);
        wait_neg(3);
        i_resetn = 1'b1;

        v0 = valid_cnt;
        send_frame(8'h77, 8, -1, 8'h00, din);
        check("post_rst_no_valid", valid_cnt - v0, 0);
        check("post_rst_link", o_link_active, 1'b1);
        v0 = valid_cnt;
        send_frame(8'h99, 8, -1, 8'h00, din);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_rx", o_rx_data, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
